// File: rtl/minimac3_pkg.sv
// Shared definitions for the minimac3 packet memory: slot-state encoding,
// Wishbone region-select offsets and control-word offsets.
package minimac3_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_READY   = 2'd2
  } slot_state_e;

  // Region select values are relative to NRXBUF (RX slots occupy 0..NRXBUF-1)
  localparam int unsigned SEL_TX_OFS     = 0;
  localparam int unsigned SEL_CTRL_OFS   = 1;

  // Control words: slot status words start at 0, drop counter sits at NRXBUF+ofs
  localparam int unsigned CW_STATUS_BASE = 0;
  localparam int unsigned CW_DROPCNT_OFS = 0;

endpackage

// File: rtl/minimac3_dpram.sv
// One-clock dual-port RAM: 8-bit port A, 32-bit port B with byte enables.
// Byte 4k+0 lives in lane 0 and appears on port B bits [31:24].
// When both ports write the same byte in one cycle, port A wins.
module minimac3_dpram #(
  parameter int unsigned AW = 11
) (
  input  logic          clk_i,
  input  logic          we_a_i,
  input  logic [AW-1:0] adr_a_i,
  input  logic [7:0]    dat_a_i,
  output logic [7:0]    dat_a_o,
  input  logic [3:0]    we_b_i,
  input  logic [AW-3:0] adr_b_i,
  input  logic [31:0]   dat_b_i,
  output logic [31:0]   dat_b_o
);

  localparam int unsigned DEPTH = 2 ** (AW - 2);

  logic [7:0] mem_q [4][DEPTH];

  // Byte-lane writes (port A applied last so it overrides port B) and registered reads
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we_b_i[2'(3 - b)]) mem_q[2'(b)][adr_b_i] <= dat_b_i[31 - 8 * b -: 8];
      if (we_a_i && (adr_a_i[1:0] == 2'(b))) mem_q[2'(b)][adr_a_i[AW-1:2]] <= dat_a_i;
    end
    dat_a_o <= mem_q[adr_a_i[1:0]][adr_a_i[AW-1:2]];
    dat_b_o <= {mem_q[0][adr_b_i], mem_q[1][adr_b_i], mem_q[2][adr_b_i], mem_q[3][adr_b_i]};
  end

endmodule

// File: rtl/minimac3_memory.sv
// minimac3 packet memory: NRXBUF receive slots plus one transmit buffer,
// all visible on a Wishbone slave port, with a control region exposing slot
// status. Optional drop counter enabled by MINIMAC3_MEMORY_DROPCNT_EN.
module minimac3_memory
  import minimac3_pkg::*;
#(
  parameter int unsigned NRXBUF    = 2,
  parameter int unsigned BUF_AW    = 11,
  parameter int unsigned DROPCNT_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic              wb_we_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  input  logic [7:0]        rx_dat,
  input  logic              rx_we,
  input  logic              rx_eop,
  input  logic              rx_abort,
  output logic              rx_ready,
  input  logic [BUF_AW-1:0] tx_adr,
  output logic [7:0]        tx_dat,
  output logic              irq_rx
);

  localparam int unsigned     CNT_W    = BUF_AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [2:0]      SEL_TX   = 3'(NRXBUF + SEL_TX_OFS);
  localparam logic [2:0]      SEL_CTRL = 3'(NRXBUF + SEL_CTRL_OFS);
  localparam logic [BUF_AW-3:0] CW_DROP = (BUF_AW-2)'(NRXBUF + CW_DROPCNT_OFS);

  logic [2:0]        wb_sel;
  logic [BUF_AW-3:0] wb_word;
  logic              wb_req, wb_wr, ctrl_wr;

  slot_state_e       state_q [NRXBUF];
  logic [CNT_W-1:0]  len_q   [NRXBUF];
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        fill_idx_q;
  logic              discard_q;

  logic              ack_q;
  logic [2:0]        rd_sel_q;
  logic [31:0]       ctrl_rd_q, ctrl_rd, drop_word;

  logic              any_empty, any_ready, any_filling;
  logic [1:0]        low_empty;
  logic              rx_start, rx_fill_wr;
  logic [BUF_AW-1:0] rx_wr_adr;
  logic              rx_we_vec [NRXBUF];
  logic [3:0]        wb_be_rx  [NRXBUF];
  logic [7:0]        rx_rd_a   [NRXBUF];
  logic [31:0]       rx_rd_b   [NRXBUF];
  logic [31:0]       tx_rd_b;
  logic              rx_unused, adr_unused;

  assign wb_sel  = wb_adr_i[BUF_AW+2:BUF_AW];
  assign wb_word = wb_adr_i[BUF_AW-1:2];
  assign wb_req  = wb_cyc_i && wb_stb_i && !ack_q;
  assign wb_wr   = wb_req && wb_we_i;
  assign ctrl_wr = wb_wr && (wb_sel == SEL_CTRL);

  assign adr_unused = ^{wb_adr_i[31:BUF_AW+3], wb_adr_i[1:0]};

  // Slot summary: availability, pending frames and lowest free slot
  always_comb begin
    any_empty   = 1'b0;
    any_ready   = 1'b0;
    any_filling = 1'b0;
    low_empty   = '0;
    for (int unsigned i = 0; i < NRXBUF; i++) begin
      if (state_q[i] == SLOT_EMPTY && !any_empty) begin
        any_empty = 1'b1;
        low_empty = 2'(i);
      end
      if (state_q[i] == SLOT_READY)   any_ready   = 1'b1;
      if (state_q[i] == SLOT_FILLING) any_filling = 1'b1;
    end
  end

  assign rx_ready = any_empty;
  assign irq_rx   = any_ready;

  // RX byte write steering into the slot RAMs
  always_comb begin
    rx_start   = rx_we && !any_filling && !discard_q && any_empty;
    rx_fill_wr = any_filling && rx_we && !rx_abort && (cnt_q != CNT_MAX);
    rx_wr_adr  = rx_start ? '0 : cnt_q[BUF_AW-1:0];
    for (int unsigned i = 0; i < NRXBUF; i++) begin
      rx_we_vec[i] = (rx_start && !rx_abort && (low_empty == 2'(i))) ||
                     (rx_fill_wr && (fill_idx_q == 2'(i)));
      wb_be_rx[i]  = (wb_wr && (wb_sel == 3'(i))) ? wb_sel_i : 4'b0000;
    end
  end

  // Slot state machines, frame byte counter and discard tracking
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < NRXBUF; i++) begin
        state_q[i] <= SLOT_EMPTY;
        len_q[i]   <= '0;
      end
      cnt_q      <= '0;
      fill_idx_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NRXBUF; i++) begin
        if (ctrl_wr && (wb_word == (BUF_AW-2)'(CW_STATUS_BASE + i)) &&
            state_q[i] == SLOT_READY && wb_dat_i[31:30] == SLOT_EMPTY)
          state_q[i] <= SLOT_EMPTY;
      end
      if (any_filling) begin
        for (int unsigned i = 0; i < NRXBUF; i++) begin
          if (fill_idx_q == 2'(i)) begin
            if (rx_abort) begin
              state_q[i] <= SLOT_EMPTY;
            end else if (rx_eop) begin
              state_q[i] <= SLOT_READY;
              len_q[i]   <= cnt_q + CNT_W'(rx_fill_wr);
            end
          end
        end
        if (rx_fill_wr) cnt_q <= cnt_q + 1'b1;
      end else if (discard_q) begin
        if (rx_abort || rx_eop) discard_q <= 1'b0;
      end else if (rx_we) begin
        if (any_empty) begin
          fill_idx_q <= low_empty;
          cnt_q      <= CNT_W'(1);
          for (int unsigned i = 0; i < NRXBUF; i++) begin
            if (low_empty == 2'(i) && !rx_abort) begin
              if (rx_eop) begin
                state_q[i] <= SLOT_READY;
                len_q[i]   <= CNT_W'(1);
              end else begin
                state_q[i] <= SLOT_FILLING;
              end
            end
          end
        end else if (!(rx_eop || rx_abort)) begin
          discard_q <= 1'b1;
        end
      end
    end
  end

`ifdef MINIMAC3_MEMORY_DROPCNT_EN
  logic                 drop_evt;
  logic [DROPCNT_W-1:0] dropcnt_q;

  assign drop_evt  = rx_we && !any_filling && !discard_q && !any_empty;
  assign drop_word = 32'(dropcnt_q);

  // Saturating count of frames that found no free slot; any write clears it
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dropcnt_q <= '0;
    end else if (ctrl_wr && wb_word == CW_DROP) begin
      dropcnt_q <= '0;
    end else if (drop_evt && dropcnt_q != '1) begin
      dropcnt_q <= dropcnt_q + 1'b1;
    end
  end
`else
  assign drop_word = '0;
`endif

  // Control-region read value, sampled in the request cycle
  always_comb begin
    ctrl_rd = '0;
    for (int unsigned i = 0; i < NRXBUF; i++) begin
      if (wb_word == (BUF_AW-2)'(CW_STATUS_BASE + i))
        ctrl_rd = {state_q[i], 30'b0} | 32'(len_q[i]);
    end
    if (wb_word == CW_DROP) ctrl_rd = drop_word;
  end

  // Wishbone handshake: single-cycle ack, read region remembered for the ack cycle
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ack_q     <= 1'b0;
      rd_sel_q  <= '0;
      ctrl_rd_q <= '0;
    end else begin
      ack_q <= wb_req;
      if (wb_req) begin
        rd_sel_q  <= wb_sel;
        ctrl_rd_q <= ctrl_rd;
      end
    end
  end

  // Read data is the registered RAM/control output of the selected region, zero outside ack
  always_comb begin
    wb_dat_o = '0;
    if (ack_q) begin
      for (int unsigned i = 0; i < NRXBUF; i++)
        if (rd_sel_q == 3'(i)) wb_dat_o = rx_rd_b[i];
      if (rd_sel_q == SEL_TX)   wb_dat_o = tx_rd_b;
      if (rd_sel_q == SEL_CTRL) wb_dat_o = ctrl_rd_q;
    end
  end

  assign wb_ack_o = ack_q;

  // MAC-side RX read ports are not used
  always_comb begin
    rx_unused = adr_unused;
    for (int unsigned i = 0; i < NRXBUF; i++) rx_unused = rx_unused ^ (^rx_rd_a[i]);
  end

  for (genvar i = 0; i < NRXBUF; i++) begin : g_rx
    minimac3_dpram #(.AW(BUF_AW)) u_ram (
      .clk_i   (sys_clk),
      .we_a_i  (rx_we_vec[i]),
      .adr_a_i (rx_wr_adr),
      .dat_a_i (rx_dat),
      .dat_a_o (rx_rd_a[i]),
      .we_b_i  (wb_be_rx[i]),
      .adr_b_i (wb_word),
      .dat_b_i (wb_dat_i),
      .dat_b_o (rx_rd_b[i])
    );
  end

  minimac3_dpram #(.AW(BUF_AW)) u_tx_ram (
    .clk_i   (sys_clk),
    .we_a_i  (1'b0),
    .adr_a_i (tx_adr),
    .dat_a_i (8'h00),
    .dat_a_o (tx_dat),
    .we_b_i  ((wb_wr && wb_sel == SEL_TX) ? wb_sel_i : 4'b0000),
    .adr_b_i (wb_word),
    .dat_b_i (wb_dat_i),
    .dat_b_o (tx_rd_b)
  );

endmodule
